// File: rtl/viterbi_acs_ctrl.sv
// Viterbi ACS controller: sequences a frame of symbols through four
// combinational ACS units, keeps path metrics, writes survivors, and
// hands off to traceback.
// Ports: clk/rst; start+frame_len begin a frame; sym_valid/sym_data/
// sym_ready carry symbols; acs_data/pm_out feed the ACS array, acs_pm/
// acs_addr return from it; sv_we/sv_addr/sv_wdata write survivor memory;
// tb_start/tb_ready/best_state launch traceback; busy/done give status.
module viterbi_acs_ctrl #(
  parameter logic [6:0] PM_INIT = 7'd32,
  parameter logic [6:0] NORM_TH = 7'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  frame_len,
  input  logic        sym_valid,
  input  logic [1:0]  sym_data,
  output logic        sym_ready,
  output logic [1:0]  acs_data,
  output logic [27:0] pm_out,
  input  logic [27:0] acs_pm,
  input  logic [7:0]  acs_addr,
  output logic        sv_we,
  output logic [7:0]  sv_addr,
  output logic [7:0]  sv_wdata,
  output logic        tb_start,
  input  logic        tb_ready,
  output logic [1:0]  best_state,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_TB_REQ,
    S_DONE
  } state_t;

  localparam logic [27:0] PM_RST =
    {PM_INIT, PM_INIT, PM_INIT, 7'd0};

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  step_q, step_d;
  logic [27:0] pm_q, pm_d;
  logic [1:0]  best_q, best_d;

  logic        go;
  logic        hs;
  logic        last;
  logic        norm_en;
  logic [27:0] pm_new;
  logic [1:0]  best_new;
  logic [6:0]  best_val;

  assign go   = start && (frame_len != 8'd0);
  assign hs   = (state_q == S_RUN) && sym_valid;
  assign last = (step_q == len_q - 8'd1);

  // Metrics are rebased only when every state can absorb the
  // subtraction, so relative distances are preserved exactly.
  always_comb begin
    norm_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (acs_pm[7*s +: 7] < NORM_TH) norm_en = 1'b0;
    end
    for (int s = 0; s < 4; s++) begin
      pm_new[7*s +: 7] = norm_en
        ? acs_pm[7*s +: 7] - NORM_TH
        : acs_pm[7*s +: 7];
    end
  end

  // Strict '<' keeps the lowest index on ties.
  always_comb begin
    best_new = 2'd0;
    best_val = pm_new[6:0];
    for (int s = 1; s < 4; s++) begin
      if (pm_new[7*s +: 7] < best_val) begin
        best_val = pm_new[7*s +: 7];
        best_new = s[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_RUN;
      S_RUN:    if (hs && last) state_d = S_TB_REQ;
      S_TB_REQ: if (tb_ready) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sym_ready = (state_q == S_RUN);
    acs_data  = sym_ready ? sym_data : 2'b00;
    sv_we     = hs;
    tb_start  = (state_q == S_TB_REQ);
    done      = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    len_d  = len_q;
    step_d = step_q;
    pm_d   = pm_q;
    best_d = best_q;
    if (state_q == S_IDLE && go) begin
      len_d  = frame_len;
      step_d = 8'd0;
      pm_d   = PM_RST;
    end else if (hs) begin
      step_d = step_q + 8'd1;
      pm_d   = pm_new;
      if (last) best_d = best_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= 8'd0;
      step_q <= 8'd0;
      pm_q   <= PM_RST;
      best_q <= 2'd0;
    end else begin
      len_q  <= len_d;
      step_q <= step_d;
      pm_q   <= pm_d;
      best_q <= best_d;
    end
  end

  assign pm_out     = pm_q;
  assign sv_addr    = step_q;
  assign sv_wdata   = acs_addr;
  assign best_state = best_q;

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Self-checking bench for viterbi_acs_ctrl: frame-level model plus
// directed scenarios with hand-computed expectations.
module tb_viterbi_acs_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  frame_len;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic [1:0]  acs_data;
  logic [27:0] pm_out;
  logic [27:0] acs_pm;
  logic [7:0]  acs_addr;
  logic        sv_we;
  logic [7:0]  sv_addr;
  logic [7:0]  sv_wdata;
  logic        tb_start;
  logic        tb_ready;
  logic [1:0]  best_state;
  logic        busy;
  logic        done;

  logic        use_acs;
  logic [27:0] dir_pm;
  logic [7:0]  dir_addr;

  int total = 0;
  int bad = 0;
  int we_log[$];

  always #5 clk = ~clk;

  viterbi_acs_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .acs_data(acs_data), .pm_out(pm_out),
    .acs_pm(acs_pm), .acs_addr(acs_addr), .sv_we(sv_we),
    .sv_addr(sv_addr), .sv_wdata(sv_wdata), .tb_start(tb_start),
    .tb_ready(tb_ready), .best_state(best_state), .busy(busy),
    .done(done)
  );

  function automatic logic [27:0] pk(int a3, int a2, int a1, int a0);
    logic [6:0] b3, b2, b1, b0;
    b3 = a3[6:0]; b2 = a2[6:0]; b1 = a1[6:0]; b0 = a0[6:0];
    return {b3, b2, b1, b0};
  endfunction

  function automatic int pm_of(logic [27:0] p, int s);
    return int'(p[7*s +: 7]);
  endfunction

  // Rate-1/2 (7,5) trellis: state = last two input bits, bit1 newest.
  function automatic logic [35:0] acs_fn(logic [27:0] pm,
                                         logic [1:0] sym);
    logic [27:0] np;
    logic [7:0]  ad;
    int best, cand, bm, u, s1, s0, g0, g1, s;
    np = '0;
    ad = '0;
    for (int ns = 0; ns < 4; ns++) begin
      best = 100000;
      for (int x = 0; x < 2; x++) begin
        s  = ((ns & 1) << 1) | x;
        u  = (ns >> 1) & 1;
        s1 = ns & 1;
        s0 = x;
        g0 = u ^ s1 ^ s0;
        g1 = u ^ s0;
        bm = (int'(sym[1]) ^ g0) + (int'(sym[0]) ^ g1);
        cand = pm_of(pm, s) + bm;
        if (cand < best) begin
          best = cand;
          ad[2*ns +: 2] = s[1:0];
        end
      end
      np[7*ns +: 7] = best[6:0];
    end
    return {ad, np};
  endfunction

  always_comb begin
    if (use_acs) {acs_addr, acs_pm} = acs_fn(pm_out, acs_data);
    else         {acs_addr, acs_pm} = {dir_addr, dir_pm};
  end

  // Model: phase 0 idle, 1 accepting symbols, 2 awaiting traceback,
  // 3 completion pulse.
  int          m_mode;
  int          m_len;
  int          m_step;
  int          m_best;
  logic [27:0] m_pmp;

  function automatic logic [35:0] raw_acs();
    if (use_acs) return acs_fn(m_pmp, sym_data);
    return {dir_addr, dir_pm};
  endfunction

  function automatic logic [27:0] model_next();
    logic [35:0] r;
    logic [27:0] v;
    int lo;
    r  = raw_acs();
    v  = r[27:0];
    lo = 1000;
    for (int s = 0; s < 4; s++)
      if (pm_of(v, s) < lo) lo = pm_of(v, s);
    if (lo >= 64)
      v = pk(pm_of(v, 3) - 64, pm_of(v, 2) - 64,
             pm_of(v, 1) - 64, pm_of(v, 0) - 64);
    return v;
  endfunction

  function automatic int argmin(logic [27:0] v);
    int b;
    b = 0;
    for (int s = 1; s < 4; s++)
      if (pm_of(v, s) < pm_of(v, b)) b = s;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_step <= 0;
      m_best <= 0;
      m_pmp  <= pk(32, 32, 32, 0);
    end else begin
      case (m_mode)
        0: if (start && frame_len != 0) begin
          m_mode <= 1;
          m_len  <= int'(frame_len);
          m_step <= 0;
          m_pmp  <= pk(32, 32, 32, 0);
        end
        1: if (sym_valid) begin
          m_pmp  <= model_next();
          m_step <= m_step + 1;
          if (m_step == m_len - 1) begin
            m_mode <= 2;
            m_best <= argmin(model_next());
          end
        end
        2: if (tb_ready) m_mode <= 3;
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic cmp_cycle();
    logic [35:0] r;
    logic [47:0] act, exp;
    logic        e_rdy;
    logic        e_we;
    e_rdy = (m_mode == 1);
    e_we  = e_rdy && sym_valid;
    r     = raw_acs();
    exp = {e_rdy, e_we, e_rdy ? sym_data : 2'b00, m_step[7:0],
           m_pmp, m_mode == 2, m_best[1:0], m_mode != 0,
           m_mode == 3, e_we ? r[35:28] : 8'h00};
    act = {sym_ready, sv_we, acs_data, sv_addr, pm_out, tb_start,
           best_state, busy, done, e_we ? sv_wdata : 8'h00};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle t=%0t outputs got=%h want=%h",
               $time, act, exp);
    end
    if (sv_we) we_log.push_back(int'(sv_addr));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_log(string name, int n);
    chk({name, "_count"}, we_log.size(), n);
    for (int i = 0; i < we_log.size() && i < n; i++)
      chk({name, "_addr"}, we_log[i], i);
  endtask

  task automatic do_start(int len);
    start = 1'b1;
    frame_len = len[7:0];
    tick();
    start = 1'b0;
  endtask

  task automatic send(logic [1:0] s);
    sym_valid = 1'b1;
    sym_data = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic wait_tb();
    for (int i = 0; i < 20 && !tb_start; i++) tick();
    chk("tb_start_seen", int'(tb_start), 1);
  endtask

  task automatic accept_tb();
    tb_ready = 1'b1;
    tick();
    tb_ready = 1'b0;
    chk("done_pulse", int'(done), 1);
    tick();
    chk("done_clear", int'(done), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  logic [27:0] snap;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    frame_len = 8'd0;
    sym_valid = 1'b0;
    sym_data = 2'b00;
    tb_ready = 1'b0;
    use_acs = 1'b1;
    dir_pm = '0;
    dir_addr = '0;
    #23;
    chk("rst_pm", int'(pm_out), int'(pk(32, 32, 32, 0)));
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Four all-zero symbols through the trellis.
    we_log.delete();
    do_start(4);
    tb_ready = 1'b1;
    send(2'b00);
    tb_ready = 1'b0;
    send(2'b00);
    send(2'b00);
    send(2'b00);
    chk("s1_tb_start", int'(tb_start), 1);
    chk("s1_pm0", pm_of(pm_out, 0), 0);
    chk("s1_best", int'(best_state), 0);
    chk_log("s1", 4);
    accept_tb();

    // Normalization and its threshold boundary.
    use_acs = 1'b0;
    do_start(2);
    dir_pm = pk(70, 66, 65, 64);
    dir_addr = 8'hE4;
    send(2'b01);
    chk("norm_sub", int'(pm_out), int'(pk(6, 2, 1, 0)));
    dir_pm = pk(80, 70, 63, 64);
    dir_addr = 8'h1B;
    send(2'b10);
    chk("norm_none", int'(pm_out), int'(pk(80, 70, 63, 64)));
    chk("norm_best", int'(best_state), 1);
    accept_tb();

    // Stall for three cycles mid-frame.
    use_acs = 1'b1;
    we_log.delete();
    do_start(6);
    send(2'b01);
    send(2'b10);
    snap = m_pmp;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_we", int'(sv_we), 0);
      chk("stall_addr", int'(sv_addr), 2);
      chk("stall_pm", int'(pm_out), int'(snap));
    end
    send(2'b11);
    send(2'b00);
    send(2'b01);
    send(2'b11);
    wait_tb();
    chk_log("stall", 6);
    accept_tb();

    // Tie between s2 and s1.
    use_acs = 1'b0;
    do_start(1);
    dir_pm = pk(5, 3, 3, 9);
    send(2'b00);
    chk("tie_best", int'(best_state), 1);
    accept_tb();

    // Zero-length start is ignored.
    do_start(0);
    chk("len0_busy", int'(busy), 0);
    tick();
    chk("len0_busy2", int'(busy), 0);

    // Start during a frame does not change its length.
    use_acs = 1'b1;
    we_log.delete();
    do_start(5);
    start = 1'b1;
    frame_len = 8'd2;
    send(2'b10);
    send(2'b01);
    start = 1'b0;
    for (int i = 0; i < 10 && !tb_start; i++) send(2'b00);
    chk_log("restart", 5);
    accept_tb();

    // Longest frame: addresses 0..254 with no wrap.
    use_acs = 1'b0;
    dir_pm = pk(1, 2, 3, 4);
    we_log.delete();
    do_start(255);
    for (int i = 0; i < 300 && !tb_start; i++) send(2'b00);
    chk("len255_count", we_log.size(), 255);
    if (we_log.size() > 0)
      chk("len255_last", we_log[we_log.size()-1], 254);
    chk("len255_best", int'(best_state), 3);
    accept_tb();

    // Reset in the middle of a frame.
    use_acs = 1'b1;
    do_start(6);
    send(2'b11);
    send(2'b10);
    sym_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", int'(sv_we), 0);
    chk("mid_rst_ready", int'(sym_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_addr", int'(sv_addr), 0);
    chk("mid_rst_acs", int'(acs_data), 0);
    chk("mid_rst_pm", int'(pm_out), int'(pk(32, 32, 32, 0)));
    chk("mid_rst_best", int'(best_state), 0);
    sym_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    we_log.delete();
    do_start(3);
    send(2'b01);
    send(2'b01);
    send(2'b10);
    wait_tb();
    chk_log("post_rst", 3);
    accept_tb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
